// File: rtl/fxp_mul_pipe.sv
// fxp_mul_pipe: three-stage pipelined signed fixed-point multiplier.
// Each operand and the result have their own Q-format. The block offers
// selectable rounding, saturation after rounding, per-result status flags
// and sticky status flags.
//
// Stage 1 registers the operands and rounding mode. Stage 2 registers the
// full-precision product. Stage 3 registers the rounded, saturated result
// and its flags. A single enable stalls every stage at once while the
// consumer back-pressures.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, rnd_mode)
//   rnd_mode            0 floor, 1 round-half-up, 2 round-half-even, 3 as 0
//   out_valid/out_ready result handshake (product, overflow, underflow, inexact)
//   sts_clear           clears the sticky flags (wins over a same-cycle set)
//   sts_ovf/unf/inx     sticky OR of the flags of every transferred result
module fxp_mul_pipe #(
  parameter int A_INT    = 6,
  parameter int A_FRAC   = 8,
  parameter int B_INT    = 6,
  parameter int B_FRAC   = 8,
  parameter int OUT_INT  = 6,
  parameter int OUT_FRAC = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [A_INT+A_FRAC-1:0]       a,
  input  logic [B_INT+B_FRAC-1:0]       b,
  input  logic [1:0]                    rnd_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_INT+OUT_FRAC-1:0]   product,
  output logic                          overflow,
  output logic                          underflow,
  output logic                          inexact,
  input  logic                          sts_clear,
  output logic                          sts_ovf,
  output logic                          sts_unf,
  output logic                          sts_inx
);

  localparam int A_W = A_INT + A_FRAC;
  localparam int B_W = B_INT + B_FRAC;
  localparam int PW  = A_W + B_W;
  localparam int FP  = A_FRAC + B_FRAC;
  localparam int OW  = OUT_INT + OUT_FRAC;
  localparam int SH  = (OUT_FRAC >= FP) ? (OUT_FRAC - FP) : 0;
  // Working width for the aligned/rounded value: wide enough for the
  // left-shifted product or a rounding carry, and at least one bit wider
  // than the output so that the saturation compares are exact.
  localparam int RW0 = PW + SH + 1;
  localparam int RW  = (RW0 > OW + 1) ? RW0 : (OW + 1);

  localparam logic signed [RW-1:0] MAX_V = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_V = {{(RW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic en;

  logic                  v1_reg;
  logic signed [A_W-1:0] a_reg;
  logic signed [B_W-1:0] b_reg;
  logic [1:0]            mode1_reg;

  logic                  v2_reg;
  logic signed [PW-1:0]  p_reg;
  logic [1:0]            mode2_reg;

  logic                  v3_reg;
  logic [OW-1:0]         product_reg;
  logic [2:0]            flags_reg;   // {inexact, underflow, overflow}
  logic [2:0]            sts_reg;     // {inx, unf, ovf}

  logic signed [RW-1:0]  r_next;
  logic                  inx_pre_next;
  logic [OW-1:0]         product_next;
  logic                  ovf_next;
  logic                  unf_next;
  logic                  inx_next;
  logic                  xfer;

  // The whole pipe advances unless a finished result is waiting on the consumer.
  assign en        = !v3_reg || out_ready;
  assign in_ready  = en;
  assign xfer      = v3_reg && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_reg      <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      mode1_reg   <= '0;
      v2_reg      <= 1'b0;
      p_reg       <= '0;
      mode2_reg   <= '0;
      v3_reg      <= 1'b0;
      product_reg <= '0;
      flags_reg   <= '0;
    end else if (en) begin
      v1_reg      <= in_valid;
      a_reg       <= a;
      b_reg       <= b;
      mode1_reg   <= rnd_mode;
      v2_reg      <= v1_reg;
      p_reg       <= PW'(a_reg) * PW'(b_reg);
      mode2_reg   <= mode1_reg;
      v3_reg      <= v2_reg;
      product_reg <= product_next;
      flags_reg   <= {inx_next, unf_next, ovf_next};
    end
  end

  generate
    if (OUT_FRAC >= FP) begin : g_shl
      // Output has at least as many fraction bits: alignment is exact.
      always_comb begin
        r_next       = RW'(p_reg) <<< SH;
        inx_pre_next = 1'b0;
      end
    end else begin : g_rnd
      localparam int D  = FP - OUT_FRAC;
      localparam int KW = PW - D;

      logic signed [KW-1:0] k;
      logic                 g;
      logic                 t;
      logic                 inc;

      // Upper bits of the product are the floor of P / 2^D.
      assign k = p_reg[PW-1:D];
      assign g = p_reg[D-1];

      if (D > 1) begin : g_t
        assign t = |p_reg[D-2:0];
      end else begin : g_no_t
        assign t = 1'b0;
      end

      always_comb begin
        inc = 1'b0;
        case (mode2_reg)
          2'd1:    inc = g;
          2'd2:    inc = g && (t || k[0]);
          default: inc = 1'b0;
        endcase
        // Sign-extend before adding so the rounding carry is kept.
        r_next       = RW'(k) + RW'(inc);
        inx_pre_next = |p_reg[D-1:0];
      end
    end
  endgenerate

  always_comb begin
    product_next = r_next[OW-1:0];
    ovf_next     = 1'b0;
    if (r_next > MAX_V) begin
      product_next = MAX_V[OW-1:0];
      ovf_next     = 1'b1;
    end else if (r_next < MIN_V) begin
      product_next = MIN_V[OW-1:0];
      ovf_next     = 1'b1;
    end
    unf_next = (p_reg != '0) && (product_next == '0);
    inx_next = inx_pre_next || ovf_next;
  end

  // Sticky flags accumulate on transfer only; a clear in the same cycle wins.
  always_ff @(posedge clk) begin
    if (reset || sts_clear) begin
      sts_reg <= '0;
    end else if (xfer) begin
      sts_reg <= sts_reg | flags_reg;
    end
  end

  assign out_valid = v3_reg;
  assign product   = product_reg;
  assign overflow  = flags_reg[0];
  assign underflow = flags_reg[1];
  assign inexact   = flags_reg[2];
  assign sts_ovf   = sts_reg[0];
  assign sts_unf   = sts_reg[1];
  assign sts_inx   = sts_reg[2];

endmodule

// File: doc/fxp_mul_pipe.md
Name: fxp_mul_pipe

Overview:
- Parametrised, pipelined signed fixed-point multiplier with valid/ready handshakes on input and output.
- Three selectable rounding modes, post-rounding saturation, and per-result plus sticky status flags (overflow, underflow, inexact).
- Successor to the single-format fixed-point multiplier: independent Q-formats per operand and per output, back-pressure, and correct rounding.
- Sits in the arithmetic datapath between producers and consumers that stream operand pairs.

Parameters:
- A_INT, 6, integer bits of operand a (including sign)
- A_FRAC, 8, fraction bits of operand a
- B_INT, 6, integer bits of operand b (including sign)
- B_FRAC, 8, fraction bits of operand b
- OUT_INT, 6, integer bits of product (including sign)
- OUT_FRAC, 12, fraction bits of product

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- a  in  A_INT+A_FRAC  signed operand a
- b  in  B_INT+B_FRAC  signed operand b
- rnd_mode  in  2  rounding mode: 0 truncate (floor), 1 round-half-up, 2 round-half-even, 3 treated as 0
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- product  out  OUT_INT+OUT_FRAC  signed saturated result
- overflow  out  1  result was clipped to max or min, qualified by out_valid
- underflow  out  1  exact product nonzero but product==0, qualified by out_valid
- inexact  out  1  nonzero discarded bits or saturation, qualified by out_valid
- sts_clear  in  1  clears sticky flags
- sts_ovf, sts_unf, sts_inx  out  1 each  sticky OR of the flags of every transferred result

Behaviour:
- Reset (synchronous, active-high):
  - all stage valids, product, flags and sticky bits go to 0.
  - in_ready is 1 in the cycle after reset deasserts.
  - Reset asserted mid-operation discards all in-flight data; no partial output appears.
- Pipeline: S1 registers a, b, rnd_mode; S2 registers the full product P (A_W+B_W bits, FP=A_FRAC+B_FRAC fraction bits); S3 registers the rounded, saturated result and flags.
- Latency: 3 cycles from accept (in_valid && in_ready) to out_valid, with no stall.
- Handshake:
  - Global enable is en = !out_valid || out_ready, and in_ready = en.
  - When en=0 every stage holds and product and flags stay stable.
  - Throughput is 1 per cycle while out_ready=1.
  - Bubbles (stage valid=0) propagate normally. Output transfers when out_valid && out_ready.
- Alignment, when OUT_FRAC >= FP:
  - R = P << (OUT_FRAC-FP).
  - No rounding; inexact comes only from saturation; underflow=0.
- Alignment, when OUT_FRAC < FP: with D = FP-OUT_FRAC, K = P>>>D (arithmetic), G = P[D-1], T = |P[D-2:0] (0 when D=1).
  - Mode 0: R = K.
  - Mode 1: R = K+G.
  - Mode 2: R = K + (G && (T || K[0])).
  - inexact_pre = |P[D-1:0].
- Rounding is computed one bit wider than K, so rounding carry is never lost.
- Saturation, applied after rounding:
  - If R > 2^(OW-1)-1 (OW=OUT_INT+OUT_FRAC), product = max and overflow=1.
  - If R < -2^(OW-1), product = min and overflow=1.
  - Otherwise product = R[OW-1:0].
- Flags:
  - inexact = inexact_pre || overflow.
  - underflow = (P!=0) && (product==0).
- Sticky flags:
  - On each output transfer, sts_x |= flag.
  - sts_clear takes precedence over a same-cycle set: the bit ends at 0 and the set is lost.
- rnd_mode is sampled per operand pair at accept; changing it mid-stream affects only later pairs.

Test Plan:
- Exact product, defaults, mode 0: a=0x0180 (1.5), b=0x0240 (2.25) -> product=0x03600 (3.375), all flags 0, out_valid exactly 3 cycles after accept.
- Positive saturation: a=0x1FFF, b=0x0200 (2.0) -> product=0x1FFFF, overflow=1, inexact=1. Negative saturation: a=0x2000 (-32), b=0x0200 -> product=0x20000, overflow=1.
- Rounding ties, a=0x0002, b=0x0004 (P=8, D=4) -> mode0 0, mode1 1, mode2 0; underflow=1 and inexact=1 when product=0. a=0x0002, b=0x000C (P=24) -> mode2 product=2, mode1 product=2, inexact=1.
- Back-pressure: stream 8 pairs with out_ready toggling 1,0,0,1,... -> all 8 products delivered in order, none lost or duplicated, product stable while out_valid && !out_ready, in_ready == (!out_valid || out_ready).
- Reset mid-stream: accept 2 pairs, assert reset 1 cycle -> out_valid stays 0, sticky bits 0, next accepted pair emerges after 3 cycles.
- Sticky: one overflow result then sts_clear coincident with another overflow transfer -> sts_ovf=0 next cycle; following overflow transfer sets it to 1.
